toggle_monitor: RTL and testbench

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

---
 rtl/toggle_monitor.sv | 170 +++++++++++++++++
 tb/tb_toggle_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_monitor.sv
// toggle_monitor: watches a toggling input X and measures the spacing of its edges.
// Reports an edge count, the last half-period, a lock flag once the spacing has
// matched HALF_PERIOD (+/- TOL) LOCK_N times in a row, and a sticky error flag
// for a wrong or stuck half-period.
// Build option: define TOGGLE_MONITOR_SYNC_EN to pass X through a 2-flop
// synchronizer before edge detection (all X responses move 2 cycles later).
module toggle_monitor #(
  parameter int HALF_PERIOD = 5,
  parameter int TOL         = 0,
  parameter int LOCK_N      = 3,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CLR,
  input  logic             X,
  output logic [CNT_W-1:0] TOGGLES,
  output logic [CNT_W-1:0] HALF_CYC,
  output logic             LOCKED,
  output logic             ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2,
    LOCK = 2'd3
  } state_t;

  // Window bounds are one bit wider than the counters so HALF_PERIOD+TOL never wraps;
  // a negative lower bound clamps to zero.
  localparam int              LO_INT  = (HALF_PERIOD > TOL) ? (HALF_PERIOD - TOL) : 0;
  localparam int              HI_INT  = HALF_PERIOD + TOL;
  localparam logic [CNT_W:0]  LO_B    = LO_INT[CNT_W:0];
  localparam logic [CNT_W:0]  HI_B    = HI_INT[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LOCK_B  = LOCK_N[CNT_W-1:0];

  logic x_in;

`ifdef TOGGLE_MONITOR_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for the asynchronous observed signal.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= X;
      sync2_q <= sync1_q;
    end
  end

  assign x_in = sync2_q;
`else
  assign x_in = X;
`endif

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic [CNT_W-1:0] half_cyc_q, half_cyc_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             edge_det;
  logic             in_meas;
  logic [CNT_W:0]   run_ext;
  logic             meas_good;
  logic             stuck;
  logic [CNT_W-1:0] good_inc;

  // Edge detection, window test and stuck test for the current cycle.
  always_comb begin
    edge_det  = (state_q != IDLE) && (x_in != x_q);
    in_meas   = (state_q == MEAS) || (state_q == LOCK);
    run_ext   = {1'b0, run_cnt_q};
    meas_good = (run_ext >= LO_B) && (run_ext <= HI_B);
    stuck     = in_meas && !edge_det && (run_ext > HI_B);
    good_inc  = (good_cnt_q < LOCK_B) ? (good_cnt_q + ONE) : good_cnt_q;
  end

  // Next-state and next-result logic; CLR outranks EN, edges and errors.
  always_comb begin
    state_d    = state_q;
    x_d        = x_in;
    run_cnt_d  = edge_det ? ONE : ((run_cnt_q == CNT_MAX) ? run_cnt_q : (run_cnt_q + ONE));
    good_cnt_d = good_cnt_q;
    toggles_d  = toggles_q;
    half_cyc_d = half_cyc_q;
    err_d      = err_q;

    if (CLR) begin
      toggles_d  = '0;
      half_cyc_d = '0;
      err_d      = 1'b0;
      good_cnt_d = '0;
      state_d    = EN ? SYNC : IDLE;
    end else if (!EN) begin
      state_d = IDLE;
    end else begin
      if (edge_det && (toggles_q != CNT_MAX)) begin
        toggles_d = toggles_q + ONE;
      end
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          // First edge only establishes a reference point.
          if (edge_det) state_d = MEAS;
        end
        MEAS, LOCK: begin
          if (edge_det) begin
            half_cyc_d = run_cnt_q;
            if (meas_good) begin
              good_cnt_d = good_inc;
              if (good_inc >= LOCK_B) state_d = LOCK;
            end else begin
              err_d      = 1'b1;
              good_cnt_d = '0;
              state_d    = SYNC;
            end
          end else if (stuck) begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            state_d    = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // LOCKED is registered so it tracks the LOCK state exactly.
    locked_d = (state_d == LOCK);
  end

  // State and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      x_q        <= 1'b0;
      run_cnt_q  <= '0;
      good_cnt_q <= '0;
      toggles_q  <= '0;
      half_cyc_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      run_cnt_q  <= run_cnt_d;
      good_cnt_q <= good_cnt_d;
      toggles_q  <= toggles_d;
      half_cyc_q <= half_cyc_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign TOGGLES  = toggles_q;
  assign HALF_CYC = half_cyc_q;
  assign LOCKED   = locked_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor: directed checks of toggle_monitor (default widths) plus a
// CNT_W=4 copy sharing the same stimulus for counter saturation.
module tb_toggle_monitor;

  localparam int ST_IDLE = 0;
  localparam int ST_SYNC = 1;
  localparam int ST_MEAS = 2;
  localparam int ST_LOCK = 3;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       CLR;
  logic       X;

  logic [7:0] toggles_a, half_a;
  logic       locked_a, err_a;
  logic [3:0] toggles_b, half_b;
  logic       locked_b, err_b;

  int n_checks;
  int n_fail;

  toggle_monitor dut_a (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .X(X),
    .TOGGLES(toggles_a), .HALF_CYC(half_a), .LOCKED(locked_a), .ERR(err_a)
  );

  toggle_monitor #(.CNT_W(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .X(X),
    .TOGGLES(toggles_b), .HALF_CYC(half_b), .LOCKED(locked_b), .ERR(err_b)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_edge();
    X = ~X;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_N = 1'b0;
    EN    = 1'b0;
    CLR   = 1'b0;
    X     = 1'b0;
    idle(2);
    RST_N = 1'b1;
    tick();
    chk("rst_toggles", 32'(toggles_a), 0);
    chk("rst_half",    32'(half_a),    0);
    chk("rst_locked",  32'(locked_a),  0);
    chk("rst_err",     32'(err_a),     0);

`ifndef TOGGLE_MONITOR_SYNC_EN
    chk("rst_state", 32'(dut_a.state_q), ST_IDLE);

    // Lock-in at period 5
    EN = 1'b1;
    tick();
    chk("en_sync", 32'(dut_a.state_q), ST_SYNC);
    idle(2);
    do_edge();                       // e1: reference only
    chk("e1_toggles", 32'(toggles_a), 1);
    chk("e1_state", 32'(dut_a.state_q), ST_MEAS);
    idle(4);
    do_edge();                       // e2: good 1
    chk("e2_half", 32'(half_a), 5);
    idle(4);
    do_edge();                       // e3: good 2
    idle(4);
    chk("pre_lock", 32'(locked_a), 0);
    do_edge();                       // e4: good 3 -> LOCK
    chk("e4_locked", 32'(locked_a), 1);
    chk("e4_state", 32'(dut_a.state_q), ST_LOCK);
    idle(4);
    do_edge();
    idle(4);
    do_edge();
    idle(4);
    do_edge();                       // e7
    chk("lock_toggles", 32'(toggles_a), 7);
    chk("lock_half",    32'(half_a),    5);
    chk("lock_err",     32'(err_a),     0);
    chk("lock_locked",  32'(locked_a),  1);

    // X held: stuck on the 6th edgeless cycle
    idle(5);
    chk("stuck5_err",    32'(err_a),    0);
    chk("stuck5_locked", 32'(locked_a), 1);
    tick();
    chk("stuck6_err",    32'(err_a),    1);
    chk("stuck6_locked", 32'(locked_a), 0);
    chk("stuck6_state",  32'(dut_a.state_q), ST_SYNC);
    idle(4);
    chk("stuck_sticky",  32'(err_a),    1);
    chk("stuck_half",    32'(half_a),   5);

    // Short half-period of 3 is a bad measurement
    do_edge();                       // e8: SYNC -> MEAS
    idle(2);
    do_edge();                       // e9: measured 3
    chk("bad_half",    32'(half_a), 3);
    chk("bad_state",   32'(dut_a.state_q), ST_SYNC);
    chk("bad_toggles", 32'(toggles_a), 9);
    chk("bad_err",     32'(err_a), 1);

    // CLR together with an edge
    idle(4);
    X   = ~X;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_toggles", 32'(toggles_a), 0);
    chk("clr_err",     32'(err_a),     0);
    chk("clr_half",    32'(half_a),    0);
    chk("clr_state",   32'(dut_a.state_q), ST_SYNC);
    idle(4);
    do_edge();
    idle(4);
    do_edge();
    idle(4);
    do_edge();
    idle(4);
    chk("relock_pre", 32'(locked_a), 0);
    do_edge();
    chk("relock",         32'(locked_a),  1);
    chk("relock_toggles", 32'(toggles_a), 4);
    chk("relock_half",    32'(half_a),    5);

    // EN low: IDLE, results held, no counting
    idle(4);
    EN = 1'b0;
    tick();
    chk("en0_state",  32'(dut_a.state_q), ST_IDLE);
    chk("en0_locked", 32'(locked_a), 0);
    chk("en0_half",   32'(half_a),   5);
    X = ~X;
    idle(12);
    chk("en0_toggles", 32'(toggles_a), 4);
    chk("en0_err",     32'(err_a),     0);
    EN = 1'b1;
    tick();
    idle(2);
    do_edge();
    idle(4);
    do_edge();
    chk("en1_toggles", 32'(toggles_a), 6);

    // Asynchronous reset mid-count, X moving during reset
    idle(2);
    #3;
    RST_N = 1'b0;
    #1;
    chk("arst_toggles", 32'(toggles_a), 0);
    chk("arst_half",    32'(half_a),    0);
    chk("arst_locked",  32'(locked_a),  0);
    chk("arst_err",     32'(err_a),     0);
    X = ~X;
    #3;
    RST_N = 1'b1;
    tick();
    tick();
    chk("post_rst_toggles", 32'(toggles_a), 0);
    chk("post_rst_state",   32'(dut_a.state_q), ST_SYNC);
    do_edge();
    chk("post_rst_count", 32'(toggles_a), 1);
    idle(4);

    // Saturation of the narrow copy
    repeat (14) begin
      do_edge();
      idle(4);
    end
    chk("sat_b_15", 32'(toggles_b), 15);
    repeat (5) begin
      do_edge();
      idle(4);
    end
    chk("sat_a_20",   32'(toggles_a), 20);
    chk("sat_b_hold", 32'(toggles_b), 15);
    chk("sat_half_b", 32'(half_b),    5);
    chk("sat_lock_b", 32'(locked_b),  1);
    chk("sat_err_b",  32'(err_b),     0);
`else
    // Synchronized build: X responses appear 2 cycles later
    EN = 1'b1;
    tick();
    idle(2);
    do_edge();
    chk("sync_lat0", 32'(toggles_a), 0);
    tick();
    chk("sync_lat1", 32'(toggles_a), 0);
    tick();
    chk("sync_lat2", 32'(toggles_a), 1);
    idle(2);
    repeat (14) begin
      do_edge();
      idle(4);
    end
    chk("sync_sat_a15", 32'(toggles_a), 15);
    chk("sync_sat_b15", 32'(toggles_b), 15);
    repeat (5) begin
      do_edge();
      idle(4);
    end
    chk("sync_sat_a20", 32'(toggles_a), 20);
    chk("sync_sat_b",   32'(toggles_b), 15);
    chk("sync_half",    32'(half_a),    5);
    chk("sync_locked",  32'(locked_a),  1);
    chk("sync_err",     32'(err_a),     0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
